dom_clk_rst_seq: RTL and testbench



---
 rtl/dom_clk_rst_seq_pkg.sv | 39 +++
 rtl/dom_clk_rst_seq_if.sv | 29 ++
 rtl/dom_clk_rst_seq_ch.sv | 140 ++++++++++++++
 rtl/dom_clk_rst_seq.sv | 58 +++++
 tb/tb_dom_clk_rst_seq.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dom_clk_rst_seq_pkg.sv
// Purpose : shared types for the N-domain clock/reset sequencer.
// Latency : n/a (types, constants and a pure decode function).
// Backpressure: n/a.
package dom_clk_rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    OFF      = 3'd0,
    PLL_ON   = 3'd1,
    RST_HOLD = 3'd2,
    RUN      = 3'd3,
    STOP     = 3'd4,
    FAULT    = 3'd5
  } dom_seq_state_e;

  typedef struct packed {
    logic pll_en;
    logic clk_en;
    logic arst_n;
    logic busy;
  } dom_out_t;

  // Output levels that go with each state. RST_HOLD and STOP share one
  // pattern: the clock runs while the domain reset is held asserted.
  function automatic dom_out_t state_decode(input dom_seq_state_e st);
    dom_out_t o;
    o = '0;
    case (st)
      PLL_ON:   o = '{pll_en: 1'b1, clk_en: 1'b0, arst_n: 1'b0, busy: 1'b1};
      RST_HOLD: o = '{pll_en: 1'b1, clk_en: 1'b1, arst_n: 1'b0, busy: 1'b1};
      RUN:      o = '{pll_en: 1'b1, clk_en: 1'b1, arst_n: 1'b1, busy: 1'b0};
      STOP:     o = '{pll_en: 1'b1, clk_en: 1'b1, arst_n: 1'b0, busy: 1'b1};
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dom_clk_rst_seq_if.sv
// Purpose : per-domain request/lock/status bundle between the control
//           register block (master) and the sequencer (slave).
// Ports   : en_req_i, pll_lock_i, err_clr_i into the sequencer;
//           pll_en_o, clk_en_o, arst_n_o, busy_o, err_o, state_o out of it.
interface dom_clk_rst_seq_if
  import dom_clk_rst_seq_pkg::*;
#(
  parameter int NUM_DOM = 4
);
  logic [NUM_DOM-1:0]         en_req_i;
  logic [NUM_DOM-1:0]         pll_lock_i;
  logic [NUM_DOM-1:0]         err_clr_i;
  logic [NUM_DOM-1:0]         pll_en_o;
  logic [NUM_DOM-1:0]         clk_en_o;
  logic [NUM_DOM-1:0]         arst_n_o;
  logic [NUM_DOM-1:0]         busy_o;
  logic [NUM_DOM-1:0]         err_o;
  logic [STATE_W*NUM_DOM-1:0] state_o;

  modport master (
    output en_req_i, pll_lock_i, err_clr_i,
    input  pll_en_o, clk_en_o, arst_n_o, busy_o, err_o, state_o
  );

  modport slave (
    input  en_req_i, pll_lock_i, err_clr_i,
    output pll_en_o, clk_en_o, arst_n_o, busy_o, err_o, state_o
  );
endinterface

// File: rtl/dom_clk_rst_seq_ch.sv
// Purpose : one domain channel: sequencing FSM, cycle counter, sticky
//           lock-timeout flag and optional lock qualifier
//           (DOM_SEQ_LOCK_FILTER_EN).
// Ports   : clk/rst; req_eff, pll_lock, err_clr in; pll_en, clk_en,
//           arst_n, busy, err, state out. All outputs registered.
module dom_seq_ch
  import dom_clk_rst_seq_pkg::*;
#(
  parameter int RST_HOLD_CYC    = 16,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int CNT_W           = 16,
  parameter int LOCK_STABLE_CYC = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_eff,
  input  logic           pll_lock,
  input  logic           err_clr,
  output logic           pll_en,
  output logic           clk_en,
  output logic           arst_n,
  output logic           busy,
  output logic           err,
  output dom_seq_state_e state
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

  dom_seq_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  dom_out_t         out_q;
  logic             lock_ok;

`ifdef DOM_SEQ_LOCK_FILTER_EN
  localparam int FLT_W = $clog2(LOCK_STABLE_CYC + 1);
  localparam logic [FLT_W-1:0] FLT_SAT = FLT_W'(LOCK_STABLE_CYC);

  logic [FLT_W-1:0] flt_q;

  // Count consecutive high samples, saturating; a low sample restarts.
  always_ff @(posedge clk) begin
    if (rst || !pll_lock) begin
      flt_q <= '0;
    end else if (flt_q != FLT_SAT) begin
      flt_q <= flt_q + 1'b1;
    end
  end

  // Gating with the raw bit makes loss of lock take effect immediately.
  assign lock_ok = pll_lock & (flt_q == FLT_SAT);
`else
  // No qualifier in this build; the parameter stays on the port list so
  // both builds share one instantiation.
  localparam int unused_lock_stable_cyc = LOCK_STABLE_CYC;
  assign lock_ok = pll_lock;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    case (state_q)
      OFF: begin
        if (req_eff) state_d = PLL_ON;
      end
      PLL_ON: begin
        cnt_d = cnt_q + 1'b1;
        // Abort beats lock, lock beats timeout.
        if (!req_eff) begin
          state_d = OFF;
          cnt_d   = '0;
        end else if (lock_ok) begin
          state_d = RST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = FAULT;
          cnt_d   = '0;
        end
      end
      RST_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (!req_eff) begin
          state_d = OFF;
          cnt_d   = '0;
        end else if (!lock_ok) begin
          state_d = PLL_ON;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!req_eff)      state_d = STOP;
        else if (!lock_ok) state_d = PLL_ON;
      end
      STOP: begin
        // Runs to completion regardless of request or lock.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = OFF;
          cnt_d   = '0;
        end
      end
      FAULT: begin
        if (!req_eff) state_d = OFF;
      end
      default: state_d = OFF;
    endcase

    // Entry into FAULT sets the flag even if a clear arrives the same cycle.
    if (state_d == FAULT && state_q != FAULT) err_d = 1'b1;
    else if (err_clr)                         err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      // Decode from next state so outputs move on the same edge as state.
      out_q   <= state_decode(state_d);
    end
  end

  assign pll_en = out_q.pll_en;
  assign clk_en = out_q.clk_en;
  assign arst_n = out_q.arst_n;
  assign busy   = out_q.busy;
  assign err    = err_q;
  assign state  = state_q;

endmodule

// File: rtl/dom_clk_rst_seq.sv
// Purpose : N-domain clock/reset sequencer; one dom_seq_ch per domain,
//           domains 1.. optionally gated on domain 0 being in RUN.
// Ports   : ref_clk_i, glb_rst_i (sync, active-high); bus (slave modport)
//           carries requests/locks/clears in, enables/resets/status out.
//           Optional lock qualifier: DOM_SEQ_LOCK_FILTER_EN.
module dom_clk_rst_seq
  import dom_clk_rst_seq_pkg::*;
#(
  parameter int NUM_DOM         = 4,
  parameter int RST_HOLD_CYC    = 16,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int CNT_W           = 16,
  parameter int GATE_ON_DOM0    = 1,
  parameter int LOCK_STABLE_CYC = 8
) (
  input logic              ref_clk_i,
  input logic              glb_rst_i,
  dom_clk_rst_seq_if.slave bus
);

  logic [NUM_DOM-1:0] req_eff;
  dom_seq_state_e     state [NUM_DOM];
  logic               run0;

  // Registered state, so a domain-0 exit reaches gated domains one
  // cycle later.
  assign run0 = (state[0] == RUN);

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    if (i == 0) begin : g_root
      assign req_eff[i] = bus.en_req_i[i];
    end else begin : g_gated
      assign req_eff[i] = bus.en_req_i[i] & ((GATE_ON_DOM0 != 0) ? run0 : 1'b1);
    end

    dom_seq_ch #(
      .RST_HOLD_CYC   (RST_HOLD_CYC),
      .LOCK_TIMEOUT   (LOCK_TIMEOUT),
      .CNT_W          (CNT_W),
      .LOCK_STABLE_CYC(LOCK_STABLE_CYC)
    ) u_ch (
      .clk     (ref_clk_i),
      .rst     (glb_rst_i),
      .req_eff (req_eff[i]),
      .pll_lock(bus.pll_lock_i[i]),
      .err_clr (bus.err_clr_i[i]),
      .pll_en  (bus.pll_en_o[i]),
      .clk_en  (bus.clk_en_o[i]),
      .arst_n  (bus.arst_n_o[i]),
      .busy    (bus.busy_o[i]),
      .err     (bus.err_o[i]),
      .state   (state[i])
    );

    assign bus.state_o[STATE_W*i +: STATE_W] = state[i];
  end

endmodule

// File: tb/tb_dom_clk_rst_seq.sv
// Purpose : self-checking bench for dom_clk_rst_seq; directed stimulus
//           pushes expected per-domain state transitions (state, cycle,
//           err) into queues, a negedge monitor pops and compares them.
module tb_dom_clk_rst_seq;

  localparam int NUM_DOM = 4;
`ifdef DOM_SEQ_LOCK_FILTER_EN
  localparam int LF = 8;
`else
  localparam int LF = 0;
`endif

  localparam int S_OFF = 0, S_PLL = 1, S_HOLD = 2, S_RUN = 3, S_STOP = 4, S_FAULT = 5;

  typedef struct {
    int st;
    int cyc;
    int err;
  } exp_t;

  logic ref_clk = 1'b0;
  logic glb_rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t expq [NUM_DOM][$];
  int   prev [NUM_DOM];

  always #5 ref_clk = ~ref_clk;
  always @(posedge ref_clk) cyc <= cyc + 1;

  dom_clk_rst_seq_if #(.NUM_DOM(NUM_DOM)) bus ();

  dom_clk_rst_seq #(
    .NUM_DOM(NUM_DOM), .RST_HOLD_CYC(16), .LOCK_TIMEOUT(4096),
    .CNT_W(16), .GATE_ON_DOM0(1), .LOCK_STABLE_CYC(8)
  ) dut (
    .ref_clk_i(ref_clk),
    .glb_rst_i(glb_rst),
    .bus      (bus)
  );

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // {pll_en, clk_en, arst_n, busy} per state.
  function automatic int outs_of(input int st);
    case (st)
      S_PLL:   return 4'b1001;
      S_HOLD:  return 4'b1101;
      S_RUN:   return 4'b1110;
      S_STOP:  return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  // Monitor: every state change of a domain must match the head of its queue.
  always @(negedge ref_clk) begin
    int   cur;
    exp_t e;
    for (int d = 0; d < NUM_DOM; d++) begin
      cur = int'(bus.state_o[3*d +: 3]);
      if (cur != prev[d]) begin
        if (expq[d].size() == 0) begin
          chk($sformatf("d%0d_unexpected_transition", d), cur, prev[d]);
        end else begin
          e = expq[d].pop_front();
          chk($sformatf("d%0d_state", d), cur, e.st);
          chk($sformatf("d%0d_cycle_of_state%0d", d, e.st), cyc, e.cyc);
          chk($sformatf("d%0d_err_in_state%0d", d, e.st), int'(bus.err_o[d]), e.err);
        end
        chk($sformatf("d%0d_outputs_state%0d", d, cur),
            int'({bus.pll_en_o[d], bus.clk_en_o[d], bus.arst_n_o[d], bus.busy_o[d]}),
            outs_of(cur));
        prev[d] = cur;
      end
    end
  end

  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic push(input int d, input int st, input int c, input int e = 0);
    exp_t x;
    x.st = st; x.cyc = c; x.err = e;
    expq[d].push_back(x);
  endtask

  function automatic int pending();
    int n = 0;
    for (int d = 0; d < NUM_DOM; d++) n += expq[d].size();
    return n;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    step();
    chk({name, "_pending_events"}, pending(), 0);
    for (int d = 0; d < NUM_DOM; d++) expq[d].delete();
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_state"},  int'(bus.state_o),  0);
    chk({name, "_pll_en"}, int'(bus.pll_en_o), 0);
    chk({name, "_clk_en"}, int'(bus.clk_en_o), 0);
    chk({name, "_arst_n"}, int'(bus.arst_n_o), 0);
    chk({name, "_busy"},   int'(bus.busy_o),   0);
    chk({name, "_err"},    int'(bus.err_o),    0);
  endtask

  initial begin
    int t;
    bit pat [12];
    for (int d = 0; d < NUM_DOM; d++) prev[d] = 0;
    bus.en_req_i   = '0;
    bus.pll_lock_i = '0;
    bus.err_clr_i  = '0;
    glb_rst = 1'b1;
    repeat (3) step();
    chk_reset_outs("reset");
    glb_rst = 1'b0;
    step();

    // Domain 1 requested while domain 0 is OFF: must stay OFF.
    bus.en_req_i[1]   = 1'b1;
    bus.pll_lock_i[1] = 1'b1;
    repeat (12) step();
    chk("d1_gated_while_d0_off", int'(bus.state_o[5:3]), S_OFF);

    // Domain 0 power-up, lock 5 cycles after request; domain 1 follows.
    t = cyc;
    bus.en_req_i[0] = 1'b1;
    push(0, S_PLL, t + 1);
    push(0, S_HOLD, t + 6 + LF);
    push(0, S_RUN, t + 22 + LF);
    push(1, S_PLL, t + 23 + LF);
    push(1, S_HOLD, t + 24 + LF);
    push(1, S_RUN, t + 40 + LF);
    wait_to(t + 5);
    bus.pll_lock_i[0] = 1'b1;
    drain("powerup", 200);

    // Drop domain 0: both domains pass through STOP.
    t = cyc;
    bus.en_req_i[0] = 1'b0;
    push(0, S_STOP, t + 1);
    push(0, S_OFF, t + 17);
    push(1, S_STOP, t + 2);
    push(1, S_OFF, t + 18);
    drain("cascade_stop", 100);
    bus.en_req_i[1]   = 1'b0;
    bus.pll_lock_i    = '0;
    step();

    // Lock never arrives: FAULT after 4096 PLL_ON cycles; a clear on the
    // entry edge loses to the set.
    t = cyc;
    bus.en_req_i[0] = 1'b1;
    push(0, S_PLL, t + 1);
    push(0, S_FAULT, t + 4097, 1);
    wait_to(t + 4096);
    bus.err_clr_i[0] = 1'b1;
    step();
    bus.err_clr_i[0] = 1'b0;
    drain("timeout", 50);
    chk("fault_err_still_set", int'(bus.err_o[0]), 1);
    bus.err_clr_i[0] = 1'b1;
    step();
    bus.err_clr_i[0] = 1'b0;
    chk("fault_err_cleared", int'(bus.err_o[0]), 0);
    chk("fault_held_with_req", int'(bus.state_o[2:0]), S_FAULT);
    t = cyc;
    bus.en_req_i[0] = 1'b0;
    push(0, S_OFF, t + 1);
    drain("fault_release", 20);

    // Lock glitch in RUN: back to PLL_ON without err, then relock.
    bus.pll_lock_i[0] = 1'b1;
    repeat (12) step();
    t = cyc;
    bus.en_req_i[0] = 1'b1;
    push(0, S_PLL, t + 1);
    push(0, S_HOLD, t + 2);
    push(0, S_RUN, t + 18);
    drain("steady_lock_up", 100);
    t = cyc;
    bus.pll_lock_i[0] = 1'b0;
    push(0, S_PLL, t + 1, 0);
    push(0, S_HOLD, t + 2 + LF);
    push(0, S_RUN, t + 18 + LF);
    step();
    bus.pll_lock_i[0] = 1'b1;
    drain("lock_glitch", 100);

    // Re-request during STOP: full STOP, OFF, then PLL_ON next edge.
    t = cyc;
    bus.en_req_i[0] = 1'b0;
    push(0, S_STOP, t + 1);
    push(0, S_OFF, t + 17);
    push(0, S_PLL, t + 18);
    push(0, S_HOLD, t + 19);
    push(0, S_RUN, t + 35);
    wait_to(t + 5);
    bus.en_req_i[0] = 1'b1;
    drain("rereq_in_stop", 100);
    t = cyc;
    bus.en_req_i[0] = 1'b0;
    push(0, S_STOP, t + 1);
    push(0, S_OFF, t + 17);
    drain("stop_again", 50);

    // Request dropped in the 7th RST_HOLD cycle: OFF on the next edge.
    t = cyc;
    bus.en_req_i[0] = 1'b1;
    push(0, S_PLL, t + 1);
    push(0, S_HOLD, t + 2);
    push(0, S_OFF, t + 9);
    wait_to(t + 8);
    bus.en_req_i[0] = 1'b0;
    drain("abort_rst_hold", 50);

    // Global reset in the middle of RST_HOLD.
    t = cyc;
    bus.en_req_i[0] = 1'b1;
    push(0, S_PLL, t + 1);
    push(0, S_HOLD, t + 2);
    push(0, S_OFF, t + 6);
    wait_to(t + 5);
    glb_rst = 1'b1;
    step();
    chk_reset_outs("glb_rst_mid_hold");
    bus.en_req_i[0] = 1'b0;
    step();
    glb_rst = 1'b0;
    drain("glb_rst", 20);

`ifdef DOM_SEQ_LOCK_FILTER_EN
    // Lock pattern 1,1,1,0 then steady high: RST_HOLD only after 8 clean highs.
    bus.pll_lock_i[0] = 1'b0;
    step();
    pat = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    t = cyc;
    bus.en_req_i[0] = 1'b1;
    push(0, S_PLL, t + 1);
    push(0, S_HOLD, t + 14);
    push(0, S_OFF, t + 16);
    step();
    for (int i = 0; i < 12; i++) begin
      bus.pll_lock_i[0] = pat[i];
      step();
    end
    wait_to(t + 15);
    bus.en_req_i[0] = 1'b0;
    drain("lock_filter", 50);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
